// File: rtl/display_demux.sv
// display_demux: receive side of the two-digit seven-segment multiplexer.
// Samples the {anode,seg} bus and waits for each value to be held for
// STABLE_CYCLES clocks before capturing it. Captured values are split back
// into per-digit patterns and decoded to hex nibbles. The block also flags
// digits that stop refreshing and any illegal all-low anode state.
module display_demux #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [1:0] anode,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [1:0] hex_ok,
  output logic [1:0] valid,
  output logic [1:0] update,
  output logic [1:0] stale,
  output logic       conflict
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT_CYCLES);

  // Returns {legal, nibble}; unknown patterns decode to {0, 4'h0}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [8:0]    s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          loaded_q, loaded_d;
  logic [6:0]    disp0_q, disp0_d, disp1_q, disp1_d;
  logic [3:0]    hex0_q, hex0_d, hex1_q, hex1_d;
  logic [1:0]    hex_ok_q, hex_ok_d;
  logic [1:0]    valid_q, valid_d;
  logic [1:0]    update_q, update_d;
  logic [TW-1:0] tmo0_q, tmo0_d, tmo1_q, tmo1_d;
  logic [1:0]    stale_q, stale_d;
  logic          conflict_q, conflict_d;

  logic [8:0]    bus;
  logic          same;
  logic          capture;
  logic          cap0;
  logic          cap1;
  logic [4:0]    dec;

  // Next-state logic: stability counting, capture decision, demux, timeouts.
  always_comb begin
    bus      = {anode, seg};
    same     = (bus == s_q);
    s_d      = bus;
    loaded_d = 1'b1;
    dec      = decode(s_q[6:0]);

    // done_q blocks a second capture within one dwell; cnt saturation alone
    // would not stop the reset-value bus from ever matching.
    capture = same && !done_q && (cnt_q == CNT_LAST) &&
              ((s_q[8:7] == 2'b10) || (s_q[8:7] == 2'b01));
    cap0    = capture && (s_q[8:7] == 2'b10);
    cap1    = capture && (s_q[8:7] == 2'b01);

    if (!same)                 cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    else                       cnt_d = cnt_q;

    if (!same)       done_d = 1'b0;
    else if (capture) done_d = 1'b1;
    else             done_d = done_q;

    disp0_d  = cap0 ? s_q[6:0] : disp0_q;
    hex0_d   = cap0 ? dec[3:0] : hex0_q;
    disp1_d  = cap1 ? s_q[6:0] : disp1_q;
    hex1_d   = cap1 ? dec[3:0] : hex1_q;
    hex_ok_d = {cap1 ? dec[4] : hex_ok_q[1], cap0 ? dec[4] : hex_ok_q[0]};
    valid_d  = valid_q | {cap1, cap0};
    update_d = {cap1, cap0};

    if (cap0)                  tmo0_d = '0;
    else if (tmo0_q != TMO_SAT) tmo0_d = tmo0_q + 1'b1;
    else                       tmo0_d = tmo0_q;

    if (cap1)                  tmo1_d = '0;
    else if (tmo1_q != TMO_SAT) tmo1_d = tmo1_q + 1'b1;
    else                       tmo1_d = tmo1_q;

    stale_d = {tmo1_d == TMO_SAT, tmo0_d == TMO_SAT};

    // s_q holds a reset value, not a sampled bus, until loaded_q is set.
    conflict_d = conflict_q | (loaded_q && (s_q[8:7] == 2'b00));
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b1;
      loaded_q   <= 1'b0;
      disp0_q    <= '0;
      disp1_q    <= '0;
      hex0_q     <= '0;
      hex1_q     <= '0;
      hex_ok_q   <= '0;
      valid_q    <= '0;
      update_q   <= '0;
      tmo0_q     <= '0;
      tmo1_q     <= '0;
      stale_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
      disp0_q    <= disp0_d;
      disp1_q    <= disp1_d;
      hex0_q     <= hex0_d;
      hex1_q     <= hex1_d;
      hex_ok_q   <= hex_ok_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
      tmo0_q     <= tmo0_d;
      tmo1_q     <= tmo1_d;
      stale_q    <= stale_d;
      conflict_q <= conflict_d;
    end
  end

  assign disp0    = disp0_q;
  assign disp1    = disp1_q;
  assign hex0     = hex0_q;
  assign hex1     = hex1_q;
  assign hex_ok   = hex_ok_q;
  assign valid    = valid_q;
  assign update   = update_q;
  assign stale    = stale_q;
  assign conflict = conflict_q;

endmodule

// File: doc/display_demux.md
# display_demux

Receive-side counterpart of the two-digit seven-segment display multiplexer. Samples the multiplexed `seg`/`anode` bus, de-glitches it, demultiplexes it back into two per-digit segment patterns, and decodes each pattern to a hex nibble. Used in loopback self-test and on-board checking of the display path. It also flags digits that have stopped refreshing and illegal anode states.

## Interface
Parameters:
- `STABLE_CYCLES`, 4: number of consecutive clocks a `{anode,seg}` value must be held before it is captured; legal range ≥1.
- `TIMEOUT_CYCLES`, 1024: number of clocks without a capture before a digit is flagged stale; legal range ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock. The mux bus is synchronous to this clock.
- `rst` in 1: asynchronous, active-high reset.
- `seg` in 7: segment bus, `{g,f,e,d,c,b,a}`; 1 = segment lit.
- `anode` in 2: digit select. `2'b10` = digit 0, `2'b01` = digit 1, `2'b11` = blank, `2'b00` = illegal.
- `disp0`, `disp1` out 7: last captured raw pattern for each digit.
- `hex0`, `hex1` out 4: decoded nibble for each digit.
- `hex_ok` out 2: bit i = 1 when `disp<i>` is a legal hex glyph.
- `valid` out 2: bit i = 1 once digit i has been captured since reset.
- `update` out 2: bit i pulses for one clock when digit i is captured.
- `stale` out 2: bit i = 1 when digit i has gone `TIMEOUT_CYCLES` clocks without a capture.
- `conflict` out 1: sticky flag; set when `anode==2'b00` is sampled.

## Operation
- **Input register:** `{anode,seg}` is registered every clock into `s_q`.
- **Stability counter `cnt`:**
  - Cleared to 0 when the live input differs from `s_q`.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
- **Capture:**
  - Fires on the clock where `cnt` reaches `STABLE_CYCLES-1` with the input still equal to `s_q`.
  - Only if `s_q.anode` is `2'b10` (digit 0) or `2'b01` (digit 1).
  - Fires once per dwell. No re-capture until the input changes and is held stable again.
- **On capture of digit i:**
  - `disp<i>` ← `s_q.seg`; `hex<i>`/`hex_ok[i]` are updated from the same value on the same edge.
  - `valid[i]` ← 1; `update[i]` = 1 for that one clock.
  - Stale counter i ← 0.
- **Decode table** (seg hex → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. Any other pattern gives `hex_ok[i]=0` and `hex<i>=0`.
- **Blank / illegal anode:**
  - `anode==2'b11`: no capture, no flag.
  - `anode==2'b00`: no capture; `conflict` ← 1, held until reset.
- **Stale counter (one per digit):**
  - Increments every clock and saturates at `TIMEOUT_CYCLES`.
  - `stale[i]` = (counter i == `TIMEOUT_CYCLES`).
  - A capture clears both the counter and `stale[i]` on the capture edge.
- **Repeats and alternation:**
  - Identical repeated captures of a digit still pulse `update` and clear the stale counter.
  - Alternating digits at any dwell ≥ `STABLE_CYCLES+1` clocks captures both digits independently.

## Timing
- **Reset values:**
  - All outputs are 0.
  - `s_q`, `cnt` and both stale counters are 0.
  - The capture-done flag is 1, so the reset-value bus is never captured.
- **Capture latency:** input applied before edge E0 and held through E`STABLE_CYCLES` → `disp`/`hex`/`update`/`valid` become visible after edge E`STABLE_CYCLES`.
- **Short dwell:** any change before E`STABLE_CYCLES` restarts the count; no capture and no `update` for that dwell.
- **Stale timing:** `stale[i]` rises exactly `TIMEOUT_CYCLES` edges after the last capture (or after reset release) of digit i.
- **`conflict` timing:** set on the edge after `2'b00` is registered into `s_q`.
- **Reset mid-operation:** all outputs and state clear immediately (asynchronous). After release, capture requires a full new stable dwell.
- **`update` bits:** at most one bit of `update` is high in any clock.

## Test plan
- **Reset behaviour:** reset, then hold `anode=2'b10`, `seg=7'h5B` for 5 clocks (`STABLE_CYCLES=4`) → one `update[0]` pulse after E4; `disp0=5B`, `hex0=2`, `hex_ok[0]=1`, `valid=2'b01`.
- **Alternating digits:** alternate `2'b10/7'h06` and `2'b01/7'h71`, 8 clocks each, for 10 periods → `hex0=1`, `hex1=F`; exactly 10 `update[0]` and 10 `update[1]` pulses; `stale=0`.
- **Short-dwell glitch:** digit 1 shown with `seg=7'h7F` for 3 clocks, then back to digit 0 → `disp1` unchanged and no `update[1]`.
- **Invalid glyph and conflict:** digit 0 shows `seg=7'h01` → `hex_ok[0]=0`, `hex0=0`. Then drive `anode=2'b00` for 1 clock → `conflict=1`, held until reset.
- **Stale detection:** `TIMEOUT_CYCLES=16`; capture digit 1, then drive `anode=2'b11` for 20 clocks → `stale[1]` rises exactly 16 edges after the capture edge. A new capture clears it on the capture edge.
- **Reset mid-dwell:** assert `rst` at clock 2 of a stable digit-0 dwell → outputs are 0 immediately. After release, a fresh 5-clock dwell is required to capture.
